jh_rf_meas_seq: RTL

Measurement sequencer for the RF-signal capture engine. On one host request it runs a burst of 2^NUM_AVG_LOG2 back-to-back captures by driving the engine's start line and the RF generator enable, handshaking on the engine's done flag (`rfsig_state`), and collecting each Vpp result. It reports the truncated mean and the peak Vpp. It sits between the host/control FSM and the capture engine plus RF generator, on the 65 MHz ADC clock domain.

---
 rtl/jh_rf_meas_seq.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/jh_rf_meas_seq.sv
// ---------------------------------------------------------------------------
// jh_rf_meas_seq
//
// Measurement sequencer for the RF-signal capture engine. One host request
// runs a burst of 2**NUM_AVG_LOG2 back-to-back captures. Each capture raises
// rf_start (engine start + RF generator enable), waits for the engine done
// flag (rfsig_state), takes the Vpp result, waits for the flag to clear, and
// then idles GAP_CYCLES cycles with RF off. After the last capture the
// truncated mean and the peak Vpp are published with a one-cycle meas_done.
//
// Optional feature macro: JH_SEQ_TIMEOUT_EN
//   defined   : RUN/DRAIN are bounded by TIMEOUT_CYCLES; expiry goes to ERR
//               and raises the sticky meas_err flag (18-bit timer).
//   undefined : RUN/DRAIN wait indefinitely, meas_err is tied low and the
//               timer is only used to time the gap (16-bit timer).
//
// Ports
//   CLOCK_65     in   65 MHz ADC clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   meas_start   in   one-cycle request, accepted only in IDLE with
//                     rfsig_state low
//   meas_abort   in   level, stops any active measurement
//   rfsig_state  in   engine done flag, Vpp valid while high
//   Vpp[15:0]    in   engine peak-to-peak result
//   rf_start     out  engine start_write / RF generator enable
//   busy         out  high whenever the sequencer is not idle
//   meas_done    out  one-cycle pulse on measurement completion
//   meas_err     out  timeout flag, sticky until the next accepted start
//   vpp_avg      out  mean Vpp of the last completed measurement
//   vpp_peak     out  maximum Vpp of the last completed measurement
// ---------------------------------------------------------------------------
module jh_rf_meas_seq #(
  parameter int NUM_AVG_LOG2   = 3,
  parameter int GAP_CYCLES     = 650,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic        CLOCK_65,
  input  logic        rst_n,
  input  logic        meas_start,
  input  logic        meas_abort,
  input  logic        rfsig_state,
  input  logic [15:0] Vpp,
  output logic        rf_start,
  output logic        busy,
  output logic        meas_done,
  output logic        meas_err,
  output logic [15:0] vpp_avg,
  output logic [15:0] vpp_peak
);

  localparam int AW = 16 + NUM_AVG_LOG2;  // accumulator cannot overflow
  localparam int CW = NUM_AVG_LOG2 + 1;   // must hold the full capture count
`ifdef JH_SEQ_TIMEOUT_EN
  localparam int TW = 18;
`else
  localparam int TW = 16;
`endif

  localparam logic [CW-1:0] N_CAPS   = CW'(2 ** NUM_AVG_LOG2);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    ERR    = 3'd5,
    ABORT  = 3'd6
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           start_s;        // accepted request: clear the burst
  logic           cap_s;          // capture Vpp this edge
  logic           fin_s;          // publish results this edge
  logic           timeout_hit_s;

  logic [AW-1:0]  acc_r;
  logic [CW-1:0]  cnt_r;
  logic [15:0]    peak_r;
  logic [TW-1:0]  timer_r;

  logic           rf_start_r;
  logic           busy_r;
  logic           meas_done_r;
  logic [15:0]    vpp_avg_r;
  logic [15:0]    vpp_peak_r;

  // Unsigned maximum of two 16-bit samples.
  function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
    if (a > b) begin
      max_u16 = a;
    end else begin
      max_u16 = b;
    end
  endfunction

`ifdef JH_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  assign timeout_hit_s = (timer_r == TO_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-edge datapath controls; abort overrides everything.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    cap_s        = 1'b0;
    fin_s        = 1'b0;
    if (meas_abort && (state_r != IDLE) && (state_r != ABORT)) begin
      state_next_s = ABORT;
    end else begin
      case (state_r)
        IDLE: begin
          if (meas_start && !rfsig_state) begin
            state_next_s = RUN;
            start_s      = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          // A result arriving on the last allowed cycle is still taken.
          if (rfsig_state) begin
            state_next_s = DRAIN;
            cap_s        = 1'b1;
          end else if (timeout_hit_s) begin
            state_next_s = ERR;
          end else begin
            state_next_s = RUN;
          end
        end
        DRAIN: begin
          if (!rfsig_state) begin
            if (cnt_r == N_CAPS) begin
              state_next_s = FINISH;
            end else begin
              state_next_s = GAP;
            end
          end else if (timeout_hit_s) begin
            state_next_s = ERR;
          end else begin
            state_next_s = DRAIN;
          end
        end
        GAP: begin
          if (timer_r == GAP_LAST) begin
            state_next_s = RUN;
          end else begin
            state_next_s = GAP;
          end
        end
        FINISH: begin
          state_next_s = IDLE;
          fin_s        = 1'b1;
        end
        ERR, ABORT: begin
          // Hold off until the engine has released its done flag.
          if (!rfsig_state) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Phase timer: restarts on every state change, saturates otherwise.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if ((state_r == IDLE) || (state_next_s != state_r)) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_r != TMR_MAX) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Burst accumulator, capture counter and running peak.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {AW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      peak_r <= 16'h0000;
    end else if (start_s) begin
      acc_r  <= {AW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      peak_r <= 16'h0000;
    end else if (cap_s) begin
      acc_r  <= acc_r + {{NUM_AVG_LOG2{1'b0}}, Vpp};
      cnt_r  <= cnt_r + CW'(1);
      peak_r <= max_u16(peak_r, Vpp);
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
      peak_r <= peak_r;
    end
  end

  // Registered control outputs and published results.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      rf_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      meas_done_r <= 1'b0;
      vpp_avg_r   <= 16'h0000;
      vpp_peak_r  <= 16'h0000;
    end else begin
      rf_start_r  <= (state_next_s == RUN);
      busy_r      <= (state_next_s != IDLE);
      meas_done_r <= fin_s;
      if (fin_s) begin
        // Dropping the low bits of the sum is the truncating mean.
        vpp_avg_r  <= acc_r[AW-1:NUM_AVG_LOG2];
        vpp_peak_r <= peak_r;
      end else begin
        vpp_avg_r  <= vpp_avg_r;
        vpp_peak_r <= vpp_peak_r;
      end
    end
  end

`ifdef JH_SEQ_TIMEOUT_EN
  logic meas_err_r;

  // Sticky timeout flag, cleared only by an accepted request.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      meas_err_r <= 1'b0;
    end else if (start_s) begin
      meas_err_r <= 1'b0;
    end else if ((state_next_s == ERR) && (state_r != ERR)) begin
      meas_err_r <= 1'b1;
    end else begin
      meas_err_r <= meas_err_r;
    end
  end

  assign meas_err = meas_err_r;
`else
  assign meas_err = 1'b0;
`endif

  assign rf_start  = rf_start_r;
  assign busy      = busy_r;
  assign meas_done = meas_done_r;
  assign vpp_avg   = vpp_avg_r;
  assign vpp_peak  = vpp_peak_r;

endmodule
